phase_sequencer: RTL and testbench

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

---
 rtl/cpu_pkg.sv | 59 +++++
 rtl/opcode_decode.sv | 61 ++++++
 rtl/phase_sequencer.sv | 132 +++++++++++++
 tb/tb_phase_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the phase sequencer: opcodes, select codes, FSM states.
// Pure declarations plus two small helpers; no logic of its own.
// Imported by the decoder and the sequencer top.
package cpu_pkg;

   // Recognised opcode bytes
   localparam logic [7:0] OP_PUSH_EBP   = 8'h55;
   localparam logic [7:0] OP_POP_EBP    = 8'h5D;
   localparam logic [7:0] OP_MOV_RM     = 8'h89;
   localparam logic [7:0] OP_PUSH_IMM8  = 8'h6A;
   localparam logic [7:0] OP_NOP        = 8'h90;

   // The only ModRM byte accepted after 0x89 (mov ebp,esp)
   localparam logic [7:0] MODRM_EBP_ESP = 8'hE5;

   // Phase-3 register-read codes
   localparam logic [3:0] SEL1_NONE     = 4'd0;
   localparam logic [3:0] SEL1_ESP      = 4'd1;
   localparam logic [3:0] SEL1_EBP      = 4'd2;
   localparam logic [3:0] SEL1_IMM      = 4'd3;
   localparam logic [3:0] SEL1_ESP_POP  = 4'd4;

   // Phase-5 register-read codes (codes 1/2 both read ebp, 0/3 read nothing)
   localparam logic [3:0] SEL2_NONE     = 4'd0;
   localparam logic [3:0] SEL2_EBP      = 4'd1;
   localparam logic [3:0] SEL2_EBP_ALT  = 4'd2;
   localparam logic [3:0] SEL2_NONE_ALT = 4'd3;
   localparam logic [3:0] SEL2_ESP      = 4'd4;

   // Sequencer states, one per phase strobe
   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      PH3    = 3'd2,
      PH4    = 3'd3,
      PH5    = 3'd4
   } state_t;

   // One-hot strobe pattern {clock_5..clock_1} for a given state
   function automatic logic [4:0] strobe_of(input state_t s);
      logic [4:0] r;
      r = 5'b00000;
      case (s)
         FETCH:   r = 5'b00001;
         DECODE:  r = 5'b00010;
         PH3:     r = 5'b00100;
         PH4:     r = 5'b01000;
         PH5:     r = 5'b10000;
         default: r = 5'b00001;
      endcase
      return r;
   endfunction

   // Sign-extend an 8-bit immediate to 32 bits
   function automatic logic [31:0] sign_extend8(input logic [7:0] b);
      return {{24{b[7]}}, b};
   endfunction

endpackage

// File: rtl/opcode_decode.sv
// Combinational decode table: opcode (+ operand) -> selects, length, legality.
// Zero latency; purely combinational, no flow control.
// needs_operand is valid from the opcode alone so the sequencer can ask for byte 2.
module opcode_decode
   import cpu_pkg::*;
(
   input  logic [7:0] opcode,
   input  logic [7:0] operand,
   output logic [3:0] select_1,
   output logic [3:0] select_2,
   output logic [2:0] length,
   output logic       needs_operand,
   output logic       legal
);

   // Table lookup; anything not listed decodes as illegal with zero selects
   always_comb begin
      select_1      = SEL1_NONE;
      select_2      = SEL2_NONE;
      length        = 3'd0;
      needs_operand = 1'b0;
      legal         = 1'b0;
      case (opcode)
         OP_PUSH_EBP: begin
            select_1 = SEL1_ESP;
            select_2 = SEL2_EBP;
            length   = 3'd1;
            legal    = 1'b1;
         end
         OP_POP_EBP: begin
            select_1 = SEL1_ESP_POP;
            select_2 = SEL2_ESP;
            length   = 3'd1;
            legal    = 1'b1;
         end
         OP_NOP: begin
            length   = 3'd1;
            legal    = 1'b1;
         end
         OP_PUSH_IMM8: begin
            select_1      = SEL1_IMM;
            select_2      = SEL2_ESP;
            length        = 3'd2;
            needs_operand = 1'b1;
            legal         = 1'b1;
         end
         OP_MOV_RM: begin
            // Only the ebp,esp form is supported; other ModRM bytes are illegal
            length        = 3'd2;
            needs_operand = 1'b1;
            if (operand == MODRM_EBP_ESP) begin
               select_1 = SEL1_ESP;
               select_2 = SEL2_NONE_ALT;
               legal    = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/phase_sequencer.sv
// Five-phase instruction sequencer: FETCH, DECODE, PH3, PH4, PH5 with one-hot strobes.
// 1-byte instruction takes 5 cycles FETCH..PH5; 2-byte adds one DECODE cycle per missing operand cycle.
// Stalls in FETCH/DECODE via instr_ready, in PH4 while mem_busy; all outputs registered.
module phase_sequencer
   import cpu_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        instr_valid,
   input  logic [7:0]  instr_data,
   output logic        instr_ready,
   input  logic        mem_busy,
   output logic        clock_1,
   output logic        clock_2,
   output logic        clock_3,
   output logic        clock_4,
   output logic        clock_5,
   output logic [3:0]  select_1,
   output logic [3:0]  select_2,
   output logic [31:0] imm_data,
   output logic [2:0]  eip_inc,
   output logic        illegal
);

   state_t      state;
   logic [4:0]  phase;
   logic [7:0]  opcode_q;
   logic [2:0]  length_q;

   logic [7:0]  dec_opcode;
   logic [3:0]  dec_select_1;
   logic [3:0]  dec_select_2;
   logic [2:0]  dec_length;
   logic        dec_needs_operand;
   logic        dec_legal;
   logic        handshake;

   assign handshake = instr_valid && instr_ready;

   // In FETCH the decoder inspects the arriving byte to learn whether an operand
   // follows; from DECODE on it inspects the latched opcode with the live operand byte.
   assign dec_opcode = (state == FETCH) ? instr_data : opcode_q;

   opcode_decode u_decode (
      .opcode        (dec_opcode),
      .operand       (instr_data),
      .select_1      (dec_select_1),
      .select_2      (dec_select_2),
      .length        (dec_length),
      .needs_operand (dec_needs_operand),
      .legal         (dec_legal)
   );

   assign {clock_5, clock_4, clock_3, clock_2, clock_1} = phase;

   // Sequencer FSM; every output is a register updated together with the state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state       <= FETCH;
         phase       <= strobe_of(FETCH);
         instr_ready <= 1'b1;
         opcode_q    <= 8'h00;
         length_q    <= 3'd0;
         select_1    <= SEL1_NONE;
         select_2    <= SEL2_NONE;
         imm_data    <= 32'h0000_0000;
         eip_inc     <= 3'd0;
         illegal     <= 1'b0;
      end else begin
         illegal <= 1'b0;
         eip_inc <= 3'd0;
         case (state)
            FETCH: begin
               if (handshake) begin
                  opcode_q    <= instr_data;
                  state       <= DECODE;
                  phase       <= strobe_of(DECODE);
                  // Keep accepting only if this opcode carries an operand byte
                  instr_ready <= dec_needs_operand;
               end
            end
            DECODE: begin
               // One-byte opcodes leave immediately (instr_ready is low);
               // two-byte opcodes wait for the operand handshake.
               if (!instr_ready || instr_valid) begin
                  if (dec_legal) begin
                     select_1    <= dec_select_1;
                     select_2    <= dec_select_2;
                     imm_data    <= (dec_select_1 == SEL1_IMM) ?
                                    sign_extend8(instr_data) : 32'h0000_0000;
                     length_q    <= dec_length;
                     instr_ready <= 1'b0;
                     state       <= PH3;
                     phase       <= strobe_of(PH3);
                  end else begin
                     select_1    <= SEL1_NONE;
                     select_2    <= SEL2_NONE;
                     imm_data    <= 32'h0000_0000;
                     length_q    <= 3'd0;
                     illegal     <= 1'b1;
                     instr_ready <= 1'b1;
                     state       <= FETCH;
                     phase       <= strobe_of(FETCH);
                  end
               end
            end
            PH3: begin
               state <= PH4;
               phase <= strobe_of(PH4);
            end
            PH4: begin
               if (!mem_busy) begin
                  eip_inc <= length_q;
                  state   <= PH5;
                  phase   <= strobe_of(PH5);
               end
            end
            PH5: begin
               instr_ready <= 1'b1;
               state       <= FETCH;
               phase       <= strobe_of(FETCH);
            end
            default: begin
               instr_ready <= 1'b1;
               state       <= FETCH;
               phase       <= strobe_of(FETCH);
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed-vector bench for phase_sequencer.
// Inputs driven and outputs sampled on the falling edge.
// Each scenario task does its own comparisons.
module tb_phase_sequencer;

   logic        clock;
   logic        reset;
   logic        instr_valid;
   logic [7:0]  instr_data;
   logic        instr_ready;
   logic        mem_busy;
   logic        clock_1, clock_2, clock_3, clock_4, clock_5;
   logic [3:0]  select_1;
   logic [3:0]  select_2;
   logic [31:0] imm_data;
   logic [2:0]  eip_inc;
   logic        illegal;
   logic [4:0]  ph;

   int errors = 0;
   int checks = 0;

   assign ph = {clock_5, clock_4, clock_3, clock_2, clock_1};

   phase_sequencer dut (
      .clock       (clock),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_data  (instr_data),
      .instr_ready (instr_ready),
      .mem_busy    (mem_busy),
      .clock_1     (clock_1),
      .clock_2     (clock_2),
      .clock_3     (clock_3),
      .clock_4     (clock_4),
      .clock_5     (clock_5),
      .select_1    (select_1),
      .select_2    (select_2),
      .imm_data    (imm_data),
      .eip_inc     (eip_inc),
      .illegal     (illegal)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step;
      @(posedge clock);
      @(negedge clock);
   endtask

   task automatic test_reset;
      reset = 1'b1; instr_valid = 1'b0; instr_data = 8'h00; mem_busy = 1'b0;
      #1;
      checks++;
      if ({ph, instr_ready, select_1, select_2, imm_data, eip_inc, illegal} !==
          {5'b00001, 1'b1, 4'd0, 4'd0, 32'd0, 3'd0, 1'b0}) begin
         errors++;
         $display("FAIL reset_values: ph=%b rdy=%b s1=%0d s2=%0d imm=%h eip=%0d ill=%b, want ph=00001 rdy=1 rest 0",
                  ph, instr_ready, select_1, select_2, imm_data, eip_inc, illegal);
      end
      step; step;
      reset = 1'b0;
      step;
      checks++;
      if ({ph, instr_ready, illegal} !== {5'b00001, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_idle: ph=%b rdy=%b ill=%b want 00001 1 0", ph, instr_ready, illegal);
      end
   endtask

   task automatic test_push_ebp;
      instr_valid = 1'b1; instr_data = 8'h55;
      step;
      checks++;
      if ({ph, instr_ready} !== {5'b00010, 1'b0}) begin
         errors++; $display("FAIL push_decode: ph=%b rdy=%b want 00010 0", ph, instr_ready);
      end
      step;
      checks++;
      if ({ph, select_1, select_2} !== {5'b00100, 4'd1, 4'd1}) begin
         errors++; $display("FAIL push_ph3: ph=%b s1=%0d s2=%0d want 00100 1 1", ph, select_1, select_2);
      end
      step;
      checks++;
      if ({ph, eip_inc} !== {5'b01000, 3'd0}) begin
         errors++; $display("FAIL push_ph4: ph=%b eip=%0d want 01000 0", ph, eip_inc);
      end
      instr_valid = 1'b0;
      step;
      checks++;
      if ({ph, eip_inc} !== {5'b10000, 3'd1}) begin
         errors++; $display("FAIL push_ph5: ph=%b eip=%0d want 10000 1", ph, eip_inc);
      end
      step;
      checks++;
      if ({ph, eip_inc, instr_ready, select_1, select_2} !== {5'b00001, 3'd0, 1'b1, 4'd1, 4'd1}) begin
         errors++; $display("FAIL push_return: ph=%b eip=%0d rdy=%b s1=%0d s2=%0d want 00001 0 1 1 1",
                            ph, eip_inc, instr_ready, select_1, select_2);
      end
   endtask

   task automatic test_push_imm;
      instr_valid = 1'b1; instr_data = 8'h6A;
      step;
      instr_valid = 1'b0; instr_data = 8'h00;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({ph, instr_ready} !== {5'b00010, 1'b1}) begin
            errors++; $display("FAIL imm_decode_hold%0d: ph=%b rdy=%b want 00010 1", i, ph, instr_ready);
         end
         if (i == 2) begin
            instr_valid = 1'b1; instr_data = 8'h80;
         end
         step;
      end
      instr_valid = 1'b0;
      checks++;
      if ({ph, select_1, select_2, imm_data} !== {5'b00100, 4'd3, 4'd4, 32'hFFFF_FF80}) begin
         errors++; $display("FAIL imm_ph3: ph=%b s1=%0d s2=%0d imm=%h want 00100 3 4 ffffff80",
                            ph, select_1, select_2, imm_data);
      end
      step; step;
      checks++;
      if ({ph, eip_inc} !== {5'b10000, 3'd2}) begin
         errors++; $display("FAIL imm_ph5: ph=%b eip=%0d want 10000 2", ph, eip_inc);
      end
      step;
      checks++;
      if ({ph, eip_inc, imm_data} !== {5'b00001, 3'd0, 32'hFFFF_FF80}) begin
         errors++; $display("FAIL imm_hold: ph=%b eip=%0d imm=%h want 00001 0 ffffff80", ph, eip_inc, imm_data);
      end
   endtask

   task automatic test_pop_busy;
      instr_valid = 1'b1; instr_data = 8'h5D;
      step;
      instr_valid = 1'b0;
      mem_busy = 1'b1;   // ignored in PH3
      step;
      checks++;
      if (ph !== 5'b00100) begin
         errors++; $display("FAIL pop_ph3: ph=%b want 00100", ph);
      end
      step;
      for (int i = 0; i < 5; i++) begin
         if (i == 4) mem_busy = 1'b0;
         checks++;
         if ({ph, eip_inc} !== {5'b01000, 3'd0}) begin
            errors++; $display("FAIL pop_ph4_cycle%0d: ph=%b eip=%0d want 01000 0", i, ph, eip_inc);
         end
         step;
      end
      checks++;
      if ({ph, eip_inc, select_1, select_2} !== {5'b10000, 3'd1, 4'd4, 4'd4}) begin
         errors++; $display("FAIL pop_ph5: ph=%b eip=%0d s1=%0d s2=%0d want 10000 1 4 4",
                            ph, eip_inc, select_1, select_2);
      end
      step;
      checks++;
      if (ph !== 5'b00001) begin
         errors++; $display("FAIL pop_return: ph=%b want 00001", ph);
      end
   endtask

   task automatic test_illegal;
      // 0x89 with a bad ModRM byte
      instr_valid = 1'b1; instr_data = 8'h89;
      step;
      checks++;
      if ({ph, instr_ready} !== {5'b00010, 1'b1}) begin
         errors++; $display("FAIL ill89_decode: ph=%b rdy=%b want 00010 1", ph, instr_ready);
      end
      instr_data = 8'hC3;
      step;
      instr_valid = 1'b0;
      checks++;
      if ({ph, illegal, select_1, select_2, imm_data, eip_inc} !==
          {5'b00001, 1'b1, 4'd0, 4'd0, 32'd0, 3'd0}) begin
         errors++; $display("FAIL ill89_pulse: ph=%b ill=%b s1=%0d s2=%0d imm=%h eip=%0d want 00001 1 0 0 0 0",
                            ph, illegal, select_1, select_2, imm_data, eip_inc);
      end
      step;
      checks++;
      if ({ph, illegal} !== {5'b00001, 1'b0}) begin
         errors++; $display("FAIL ill89_end: ph=%b ill=%b want 00001 0", ph, illegal);
      end
      // Unknown single-byte opcode
      instr_valid = 1'b1; instr_data = 8'hFF;
      step;
      instr_valid = 1'b0;
      checks++;
      if ({ph, instr_ready} !== {5'b00010, 1'b0}) begin
         errors++; $display("FAIL illff_decode: ph=%b rdy=%b want 00010 0", ph, instr_ready);
      end
      step;
      checks++;
      if ({ph, illegal, select_1, select_2, eip_inc} !== {5'b00001, 1'b1, 4'd0, 4'd0, 3'd0}) begin
         errors++; $display("FAIL illff_pulse: ph=%b ill=%b s1=%0d s2=%0d eip=%0d want 00001 1 0 0 0",
                            ph, illegal, select_1, select_2, eip_inc);
      end
      step;
      checks++;
      if ({ph, illegal} !== {5'b00001, 1'b0}) begin
         errors++; $display("FAIL illff_end: ph=%b ill=%b want 00001 0", ph, illegal);
      end
   endtask

   task automatic test_reset_mid;
      instr_valid = 1'b1; instr_data = 8'h55;
      step;
      instr_valid = 1'b0;
      mem_busy = 1'b1;
      step; step;
      checks++;
      if (ph !== 5'b01000) begin
         errors++; $display("FAIL rst_mid_in_ph4: ph=%b want 01000", ph);
      end
      reset = 1'b1;
      #1;
      checks++;
      if ({ph, instr_ready, select_1, select_2, imm_data, eip_inc, illegal} !==
          {5'b00001, 1'b1, 4'd0, 4'd0, 32'd0, 3'd0, 1'b0}) begin
         errors++; $display("FAIL rst_mid_async: ph=%b rdy=%b s1=%0d s2=%0d imm=%h eip=%0d ill=%b want 00001 1 0 0 0 0 0",
                            ph, instr_ready, select_1, select_2, imm_data, eip_inc, illegal);
      end
      mem_busy = 1'b0;
      step;
      reset = 1'b0;
      step;
      checks++;
      if ({ph, illegal, eip_inc} !== {5'b00001, 1'b0, 3'd0}) begin
         errors++; $display("FAIL rst_mid_after: ph=%b ill=%b eip=%0d want 00001 0 0", ph, illegal, eip_inc);
      end
      instr_valid = 1'b1; instr_data = 8'h90;
      step;
      instr_valid = 1'b0;
      step; step; step;
      checks++;
      if ({ph, eip_inc, select_1, select_2} !== {5'b10000, 3'd1, 4'd0, 4'd0}) begin
         errors++; $display("FAIL nop_after_rst: ph=%b eip=%0d s1=%0d s2=%0d want 10000 1 0 0",
                            ph, eip_inc, select_1, select_2);
      end
      step;
   endtask

   task automatic test_back_to_back;
      // nop then mov ebp,esp with valid held high throughout
      instr_valid = 1'b1; instr_data = 8'h90;
      step; step; step; step;
      checks++;
      if ({ph, eip_inc} !== {5'b10000, 3'd1}) begin
         errors++; $display("FAIL b2b_nop_ph5: ph=%b eip=%0d want 10000 1", ph, eip_inc);
      end
      instr_data = 8'h89;
      step;
      checks++;
      if ({ph, instr_ready, eip_inc} !== {5'b00001, 1'b1, 3'd0}) begin
         errors++; $display("FAIL b2b_fetch6: ph=%b rdy=%b eip=%0d want 00001 1 0", ph, instr_ready, eip_inc);
      end
      step;
      instr_data = 8'hE5;
      checks++;
      if ({ph, instr_ready} !== {5'b00010, 1'b1}) begin
         errors++; $display("FAIL b2b_mov_decode: ph=%b rdy=%b want 00010 1", ph, instr_ready);
      end
      step;
      instr_valid = 1'b0;
      checks++;
      if ({ph, select_1, select_2, imm_data} !== {5'b00100, 4'd1, 4'd3, 32'd0}) begin
         errors++; $display("FAIL b2b_mov_ph3: ph=%b s1=%0d s2=%0d imm=%h want 00100 1 3 0",
                            ph, select_1, select_2, imm_data);
      end
      step; step;
      checks++;
      if ({ph, eip_inc, illegal} !== {5'b10000, 3'd2, 1'b0}) begin
         errors++; $display("FAIL b2b_mov_ph5: ph=%b eip=%0d ill=%b want 10000 2 0", ph, eip_inc, illegal);
      end
      step;
   endtask

   initial begin
      test_reset;
      test_push_ebp;
      test_push_imm;
      test_pop_busy;
      test_illegal;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
